coin_input_conditioner: RTL and testbench

Front-end stage for the vending machine that turns the raw coin-insert and accept push-button inputs into clean, single-cycle event pulses. It sits directly upstream of the credit FSM: its `m`/`a` outputs drive that FSM's coin and accept inputs. Both sides are clocked by the same prescaled internal clock. Each channel is synchronised, debounced and edge-detected. Coin and accept pulses are arbitrated so they never assert in the same cycle. The block also keeps a saturating coin-event count for debug on spare outputs.

---
 rtl/coin_input_conditioner_pkg.sv | 8 +
 rtl/coin_input_conditioner_debounce_channel.sv | 58 +++++
 rtl/coin_input_conditioner.sv | 77 +++++++
 tb/tb_coin_input_conditioner.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/coin_input_conditioner_pkg.sv
// Shared constants for the coin/accept input conditioner.
package coin_input_conditioner_pkg;

  localparam int         DEBOUNCE_CYCLES_DEF = 4;
  localparam int         SYNC_STAGES_DEF     = 2;
  localparam logic [7:0] COIN_COUNT_MAX      = 8'd255;

endpackage

// File: rtl/coin_input_conditioner_debounce_channel.sv
// One button channel: synchroniser chain, debounce counter and rise strobe.
//
// o_rise is a combinational strobe that is high in the cycle whose closing
// edge takes o_level from 0 to 1. The parent registers it, so its output
// pulse appears on the same edge as the new debounced level.
module debounce_channel
  import coin_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam logic [7:0] CNT_TC = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [7:0]             r_cnt;
  logic                   w_s;
  logic                   w_tc;

  assign w_s  = r_sync[SYNC_STAGES-1];
  assign w_tc = (r_cnt == CNT_TC);

  // Shift the raw button through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Count consecutive samples that disagree with the level; any agreeing
  // sample restarts the count so short glitches never flip the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= 1'b0;
      r_cnt   <= 8'd0;
    end else if (w_s == r_level) begin
      r_cnt <= 8'd0;
    end else if (w_tc) begin
      r_level <= w_s;
      r_cnt   <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_s & ~r_level & w_tc;

endmodule

// File: rtl/coin_input_conditioner.sv
// Turns raw coin/accept buttons into single-cycle m/a pulses for the credit
// FSM, with coin-first arbitration and a saturating debug coin count.
module coin_input_conditioner
  import coin_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_raw,
  input  logic       accept_raw,
  output logic       m,
  output logic       a,
  output logic       coin_level,
  output logic       accept_level,
  output logic [7:0] coin_count
);

  logic       w_coin_rise;
  logic       w_acc_rise;
  logic       r_m;
  logic       r_a;
  logic       r_pend_a;
  logic [7:0] r_coin_count;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_coin (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (coin_raw),
    .o_level(coin_level),
    .o_rise (w_coin_rise)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_accept (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (accept_raw),
    .o_level(accept_level),
    .o_rise (w_acc_rise)
  );

  // Coin wins a same-cycle tie; the accept is parked in pend_a for one
  // cycle. A new coin rise cannot land on the deferred slot because rises
  // on one channel are at least two debounce periods apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m      <= 1'b0;
      r_a      <= 1'b0;
      r_pend_a <= 1'b0;
    end else begin
      r_m      <= w_coin_rise;
      r_a      <= r_pend_a | (w_acc_rise & ~w_coin_rise);
      r_pend_a <= w_acc_rise & w_coin_rise;
    end
  end

  // Count issued coin pulses, holding at the maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coin_count <= 8'd0;
    end else if (r_m && (r_coin_count != COIN_COUNT_MAX)) begin
      r_coin_count <= r_coin_count + 8'd1;
    end
  end

  assign m          = r_m;
  assign a          = r_a;
  assign coin_count = r_coin_count;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner (default and DC=1/SS=3 builds).
module tb_coin_input_conditioner;

  logic       clk;
  logic       reset;
  logic       coin_raw, accept_raw;
  logic       m, a, coin_level, accept_level;
  logic [7:0] coin_count;
  logic       coin2, acc2;
  logic       m2, a2, coin_level2, accept_level2;
  logic [7:0] coin_count2;

  int n_tests = 0;
  int n_fail  = 0;

  coin_input_conditioner u_dut (
    .clk         (clk),
    .reset       (reset),
    .coin_raw    (coin_raw),
    .accept_raw  (accept_raw),
    .m           (m),
    .a           (a),
    .coin_level  (coin_level),
    .accept_level(accept_level),
    .coin_count  (coin_count)
  );

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(1),
    .SYNC_STAGES    (3)
  ) u_dut_fast (
    .clk         (clk),
    .reset       (reset),
    .coin_raw    (coin2),
    .accept_raw  (acc2),
    .m           (m2),
    .a           (a2),
    .coin_level  (coin_level2),
    .accept_level(accept_level2),
    .coin_count  (coin_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int pulses;
    int presses;
    logic [6:0] bounce;

    reset = 1'b1; coin_raw = 1'b0; accept_raw = 1'b0; coin2 = 1'b0; acc2 = 1'b0;
    idle(3);
    check_val("rst_m", m, 0);
    check_val("rst_a", a, 0);
    check_val("rst_coin_level", coin_level, 0);
    check_val("rst_accept_level", accept_level, 0);
    check_val("rst_count", coin_count, 0);
    reset = 1'b0;

    // Clean coin press: pulse on 6th edge, count one edge later.
    coin_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_val("t1_m", m, (k == 6));
      check_val("t1_level", coin_level, (k >= 6));
      check_val("t1_count", coin_count, (k >= 7));
      check_val("t1_a", a, 0);
    end
    coin_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_val("t1_rel_m", m, 0);
      check_val("t1_rel_level", coin_level, (k < 6));
    end

    // Bounced accept: 3 high, 1 low, 3 high never settles.
    bounce = 7'b1110111;
    for (int i = 0; i < 7; i++) begin
      accept_raw = bounce[6-i];
      tick();
      check_val("t2_bounce_a", a, 0);
    end
    accept_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val("t2_bounce_a_tail", a, 0);
      check_val("t2_bounce_level", accept_level, 0);
    end
    // Exactly four stable high samples is enough for one pulse.
    accept_raw = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 4) accept_raw = 1'b0;
      if (a) pulses++;
      check_val("t2_a_time", a, (k == 6));
      check_val("t2_m", m, 0);
    end
    check_val("t2_a_pulses", pulses, 1);
    check_val("t2_level_after", accept_level, 0);
    check_val("t2_count", coin_count, 1);

    // Simultaneous press: m then a on the next edge.
    coin_raw = 1'b1; accept_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_val("t3_m", m, (k == 6));
      check_val("t3_a", a, (k == 7));
      check_val("t3_excl", m & a, 0);
    end
    coin_raw = 1'b0; accept_raw = 1'b0;
    idle(10);
    check_val("t3_count", coin_count, 2);

    // Reset while the coin counter holds 2, button still held.
    coin_raw = 1'b1;
    idle(4);
    reset = 1'b1;
    tick();
    check_val("t4_m", m, 0);
    check_val("t4_a", a, 0);
    check_val("t4_coin_level", coin_level, 0);
    check_val("t4_accept_level", accept_level, 0);
    check_val("t4_count", coin_count, 0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_val("t4_m_after", m, (k == 6));
      check_val("t4_count_after", coin_count, (k >= 7));
    end
    coin_raw = 1'b0;
    idle(10);

    // Reset while an accept is pending drops it.
    coin_raw = 1'b1; accept_raw = 1'b1;
    idle(6);
    check_val("t4p_m", m, 1);
    check_val("t4p_a_not_yet", a, 0);
    reset = 1'b1; coin_raw = 1'b0; accept_raw = 1'b0;
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (a) pulses++;
    end
    check_val("t4p_a_dropped", pulses, 0);
    check_val("t4p_count", coin_count, 0);

    // Saturation over 260 clean presses.
    pulses = 0;
    for (presses = 1; presses <= 260; presses++) begin
      coin_raw = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (m) pulses++;
      end
      coin_raw = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (m) pulses++;
      end
      if (presses == 254 || presses == 255 || presses == 256 || presses == 260)
        check_val("t5_count", coin_count, (presses > 255) ? 255 : presses);
    end
    check_val("t5_m_pulses", pulses, 260);

    // DC=1, SS=3: single-cycle glitch is accepted, latency 3 edges past E0.
    coin2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) coin2 = 1'b0;
      check_val("t6_m2", m2, (k == 4));
      check_val("t6_level2", coin_level2, (k == 4));
    end
    acc2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_val("t6_a2", a2, (k == 4));
      check_val("t6_m2_quiet", m2, 0);
    end
    acc2 = 1'b0;
    idle(6);
    check_val("t6_count2", coin_count2, 1);
    check_val("t6_acc_level2", accept_level2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
